// File: rtl/game_board_mem_pkg.sv
// Shared types for the board memory: cell codes, scan FSM states and the
// helper that maps a cell code onto its bit-swapped position in the board image.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    INVALID = 2'b01,
    P2      = 2'b10,
    P1      = 2'b11
  } cell_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Board image stores each cell as {code[0], code[1]}; the swap is its own inverse.
  function automatic logic [1:0] swap_cell(input logic [1:0] code);
    return {code[0], code[1]};
  endfunction

endpackage

// File: rtl/game_board_mem_if.sv
// Bundle of the move-write, board-status and scan signals of game_board_mem.
// The master drives requests; the slave (the board memory) drives results.
interface game_board_mem_if #(
  parameter int N = 3
);
  localparam int C  = N * N;
  localparam int AW = $clog2(C);
  localparam int MW = $clog2(C + 1);

  logic            clear;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [1:0]      wr_state;
  logic            wr_ok;
  logic            wr_err;
  logic [2*C-1:0]  board;
  logic [MW-1:0]   move_count;
  logic            full;
  logic            empty;
  logic            scan_start;
  logic            scan_valid;
  logic [AW-1:0]   scan_addr;
  logic [1:0]      scan_cell;
  logic            scan_busy;

  modport master (
    output clear, wr_en, wr_addr, wr_state, scan_start,
    input  wr_ok, wr_err, board, move_count, full, empty,
    input  scan_valid, scan_addr, scan_cell, scan_busy
  );

  modport slave (
    input  clear, wr_en, wr_addr, wr_state, scan_start,
    output wr_ok, wr_err, board, move_count, full, empty,
    output scan_valid, scan_addr, scan_cell, scan_busy
  );

endinterface

// File: rtl/game_board_mem_addr_dec.sv
// One-hot cell select from a cell index; indices at or beyond C select nothing,
// which is what makes out-of-range writes fall through to a rejection.
module board_addr_dec #(
  parameter  int C  = 9,
  localparam int AW = $clog2(C)
) (
  input  logic [AW-1:0] addr_i,
  output logic [C-1:0]  onehot_o
);

  for (genvar gi = 0; gi < C; gi++) begin : g_sel
    assign onehot_o[gi] = (addr_i == AW'(gi));
  end

endmodule

// File: rtl/game_board_mem.sv
// N x N game board: write-once cells with accept/reject pulses, occupancy count,
// and a C-cycle scan that streams the live cells out one per cycle.
module game_board_mem
  import ttt_pkg::*;
#(
  parameter int N = 3  // legal range 2..8
) (
  input  logic            clk,
  input  logic            reset,
  game_board_mem_if.slave bus
);

  localparam int C  = N * N;
  localparam int AW = $clog2(C);
  localparam int MW = $clog2(C + 1);

  logic [C-1:0]  sel_onehot;
  logic [C-1:0]  occupied;
  logic [1:0]    cell_w [C];
  logic          code_ok;
  logic          target_free;
  logic          full_w;
  logic          accept;
  logic [MW-1:0] move_count_q, move_count_d;
  logic          wr_ok_q, wr_err_q;
  scan_state_t   state_q, state_d;
  logic [AW-1:0] scan_addr_q, scan_addr_d;

  board_addr_dec #(.C(C)) u_addr_dec (
    .addr_i   (bus.wr_addr),
    .onehot_o (sel_onehot)
  );

  assign code_ok     = (cell_t'(bus.wr_state) == P1) || (cell_t'(bus.wr_state) == P2);
  // An out-of-range address selects no cell, so target_free is 0 for it.
  assign target_free = |(sel_onehot & ~occupied);
  assign full_w      = (move_count_q == MW'(C));
  assign accept      = bus.wr_en & ~bus.clear & code_ok & target_free & ~full_w;

  for (genvar gi = 0; gi < C; gi++) begin : g_cell
    logic [1:0] cell_q, cell_d;

    always_comb begin
      cell_d = cell_q;
      if (bus.clear) begin
        cell_d = EMPTY;
      end else if (accept && sel_onehot[gi]) begin
        cell_d = bus.wr_state;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cell_q <= EMPTY;
      end else begin
        cell_q <= cell_d;
      end
    end

    assign cell_w[gi]             = cell_q;
    assign occupied[gi]           = |cell_q;
    assign bus.board[2*gi +: 2]   = swap_cell(cell_q);
  end

  always_comb begin
    move_count_d = move_count_q;
    if (bus.clear) begin
      move_count_d = '0;
    end else if (accept) begin
      move_count_d = move_count_q + MW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_count_q <= '0;
      wr_ok_q      <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      move_count_q <= move_count_d;
      wr_ok_q      <= accept;
      wr_err_q     <= bus.wr_en & ~accept;
    end
  end

  assign bus.wr_ok      = wr_ok_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.move_count = move_count_q;
  assign bus.full       = full_w;
  assign bus.empty      = (move_count_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      scan_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
    end
  end

  // scan_start is only looked at in IDLE, so a request on the exit cycle is dropped.
  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    if (bus.clear) begin
      state_d     = ST_IDLE;
      scan_addr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.scan_start) begin
            state_d     = ST_SCAN;
            scan_addr_d = '0;
          end
        end
        ST_SCAN: begin
          if (scan_addr_q == AW'(C - 1)) begin
            state_d     = ST_IDLE;
            scan_addr_d = '0;
          end else begin
            scan_addr_d = scan_addr_q + AW'(1);
          end
        end
        default: begin
          state_d     = ST_IDLE;
          scan_addr_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.scan_busy  = (state_q == ST_SCAN);
    bus.scan_valid = (state_q == ST_SCAN);
    bus.scan_cell  = EMPTY;
    for (int k = 0; k < C; k++) begin
      if (scan_addr_q == AW'(k)) begin
        bus.scan_cell = cell_w[k];
      end
    end
  end

  assign bus.scan_addr = scan_addr_q;

endmodule
